// File: rtl/vga_fb_reader.sv
// vga_fb_reader: read side of the VGA frame buffer.
// Generates raster timing from the system clock, fetches one pixel per pixel
// period from the buffer's BRAM read port, maps it to 4:4:4 RGB and overlays
// a crosshair at the device origin. Raster geometry is parameterised; the
// defaults give 640x480@60 from a 100 MHz clock.
module vga_fb_reader #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MARK_LEN     = 4,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        marker_en,
  input  logic [8:0]  device_x,
  input  logic [8:0]  device_y,
  output logic [18:0] rd_addr,
  output logic        rd_en,
  input  logic [7:0]  rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_done
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_W      = $clog2(H_TOTAL);
  localparam int unsigned V_W      = $clog2(V_TOTAL);
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned HV_W     = (H_W > V_W) ? H_W : V_W;
  localparam int unsigned CNT_W    = (HV_W > 9) ? HV_W : 9;
  // Two extra bits: one for zero-extension, one for the sign of the difference.
  localparam int unsigned POS_W    = CNT_W + 2;
  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

  localparam logic signed [POS_W-1:0] ARM = POS_W'(MARK_LEN);

  logic [DIV_W-1:0]  div;
  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic [ADDR_W-1:0] row_base;

  logic              smp_en;
  logic [8:0]        smp_x;
  logic [8:0]        smp_y;

  logic [READ_LATENCY-1:0] rd_pend;
  logic [7:0]        pix_q;

  logic              vis_q;
  logic              ovl_q;
  logic              hs_q;
  logic              vs_q;

  logic              tick_c;
  logic              h_end_c;
  logic              v_end_c;
  logic              vis_c;
  logic              hs_c;
  logic              vs_c;
  logic              frame_start_c;
  logic              cur_en_c;
  logic [8:0]        cur_x_c;
  logic [8:0]        cur_y_c;
  logic signed [POS_W-1:0] dx_c;
  logic signed [POS_W-1:0] dy_c;
  logic              ovl_c;

  // Raster decode of the current counter position.
  always_comb begin
    tick_c        = (div == DIV_W'(CLK_DIV - 1));
    h_end_c       = (h == H_W'(H_TOTAL - 1));
    v_end_c       = (v == V_W'(V_TOTAL - 1));
    vis_c         = (h < H_W'(H_VISIBLE)) && (v < V_W'(V_VISIBLE));
    hs_c          = !((h >= H_W'(HS_START)) && (h < H_W'(HS_END)));
    vs_c          = !((v >= V_W'(VS_START)) && (v < V_W'(VS_END)));
    frame_start_c = (h == '0) && (v == '0);
  end

  // Crosshair hit test; the first pixel of a frame already sees the new sample.
  always_comb begin
    cur_en_c = frame_start_c ? marker_en : smp_en;
    cur_x_c  = frame_start_c ? device_x  : smp_x;
    cur_y_c  = frame_start_c ? device_y  : smp_y;
    dx_c     = $signed(POS_W'(h)) - $signed(POS_W'(cur_x_c));
    dy_c     = $signed(POS_W'(v)) - $signed(POS_W'(cur_y_c));
    ovl_c    = cur_en_c && vis_c &&
               (((dx_c == '0) && (dy_c >= -ARM) && (dy_c <= ARM)) ||
                ((dy_c == '0) && (dx_c >= -ARM) && (dx_c <= ARM)));
  end

  // Pixel divider, raster counters and multiplier-free row base.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div      <= '0;
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else begin
      div <= tick_c ? '0 : div + DIV_W'(1);
      if (tick_c) begin
        if (h_end_c) begin
          h <= '0;
          v <= v_end_c ? '0 : v + V_W'(1);
          if (v < V_W'(V_VISIBLE - 1)) begin
            row_base <= row_base + ADDR_W'(H_VISIBLE);
          end else begin
            row_base <= '0;
          end
        end else begin
          h <= h + H_W'(1);
        end
      end
    end
  end

  // Overlay controls are frozen for a whole frame to avoid tearing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp_en <= 1'b0;
      smp_x  <= '0;
      smp_y  <= '0;
    end else if (tick_c && frame_start_c) begin
      smp_en <= marker_en;
      smp_x  <= device_x;
      smp_y  <= device_y;
    end
  end

  // Fetch request: one-clock read strobe per visible pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      rd_en   <= 1'b0;
    end else begin
      rd_en <= tick_c && vis_c;
      if (tick_c) begin
        rd_addr <= row_base + ADDR_W'(h);
      end
    end
  end

  // Capture read data when the outstanding request's latency has elapsed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend <= '0;
      pix_q   <= '0;
    end else begin
      rd_pend[0] <= rd_en;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        rd_pend[i] <= rd_pend[i-1];
      end
      if (rd_pend[READ_LATENCY-1]) begin
        pix_q <= rd_data;
      end
    end
  end

  // Per-pixel attributes travel one tick alongside the fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vis_q <= 1'b0;
      ovl_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (tick_c) begin
      vis_q <= vis_c;
      ovl_q <= ovl_c;
      hs_q  <= hs_c;
      vs_q  <= vs_c;
    end
  end

  // Video outputs: blanking, crosshair override, else 3-3-2 to 4-4-4 expansion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (tick_c) begin
      hsync <= hs_q;
      vsync <= vs_q;
      if (!vis_q) begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end else if (ovl_q) begin
        vga_r <= 4'hF;
        vga_g <= 4'h0;
        vga_b <= 4'h0;
      end else begin
        vga_r <= {pix_q[7:5], pix_q[7]};
        vga_g <= {pix_q[4:2], pix_q[4]};
        vga_b <= {pix_q[1:0], pix_q[1:0]};
      end
    end
  end

  // Vblank-start pulse, raised on the tick that moves into the first blank line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick_c && h_end_c && (v == V_W'(V_VISIBLE - 1));
    end
  end

endmodule
